fifo_write_arbiter: RTL

- Shares one sync_fifo write port (winc/wdata) between N_REQ independent producers.
- Uses round-robin arbitration with bounded burst ownership.
- Tracks FIFO occupancy itself by counting write and read strobes. From that count it derives full, empty and level, and applies backpressure to producers with a valid/ready handshake.
- Sits directly in front of sync_fifo. The consumer's rinc is also routed into this block as a monitor input.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_write_arbiter_rr_picker.sv | 29 ++
 rtl/fifo_write_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
// The arbiter is either IDLE (about to regrant) or OWN (an owner holds a burst).
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int RR_PTR_W_MIN = 1;

    function automatic int clog2_p1(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A single requester still needs a one-bit pointer.
    function automatic int ptr_width(input int nReq);
        return (nReq > 1) ? $clog2(nReq) : RR_PTR_W_MIN;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin search.
// Finds the first asserted request at or above ptr, wrapping modulo N_REQ.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    int w_cand;

    // Walk from the farthest offset down so the nearest hit is written last and wins.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = (int'(ptr) + k) % N_REQ;
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = PTR_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one sync_fifo write port between N_REQ producers.
// It uses round-robin bursts and tracks FIFO occupancy locally from the write and read strobes.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_W-1:0]     req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        rinc_mon,
    output logic                        winc,
    output logic [DATA_W-1:0]           wdata,
    output logic                        full,
    output logic                        empty,
    output logic [clog2_p1(DEPTH)-1:0]  level,
    output logic                        err_underflow
);

    localparam int PTR_W  = ptr_width(N_REQ);
    localparam int LVL_W  = clog2_p1(DEPTH);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [PTR_W-1:0]   r_rrPtr;
    logic [PTR_W-1:0]   w_nextPtr;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   w_nextOwner;
    logic [BEAT_W-1:0]  r_beats;
    logic [BEAT_W-1:0]  w_nextBeats;
    logic [LVL_W-1:0]   r_level;
    logic               r_errUnderflow;
    logic               w_found;
    logic [PTR_W-1:0]   w_grantIdx;
    logic [N_REQ-1:0]   w_ready;
    logic               w_winc;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_full;
    logic               w_empty;
    logic               w_rdEff;

    function automatic logic [PTR_W-1:0] wrapInc(input logic [PTR_W-1:0] p);
        if (int'(p) >= N_REQ - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_rdEff = rinc_mon & ~w_empty;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (r_rrPtr),
        .found (w_found),
        .idx   (w_grantIdx)
    );

    always_comb begin
        w_ready     = '0;
        w_nextState = r_state;
        w_nextPtr   = r_rrPtr;
        w_nextOwner = r_owner;
        w_nextBeats = r_beats;
        case (r_state)
            IDLE: begin
                if (w_found && !w_full) begin
                    w_ready[w_grantIdx] = 1'b1;
                    w_nextOwner         = w_grantIdx;
                    w_nextBeats         = BEAT_W'(1);
                    if (MAX_BURST > 1) begin
                        w_nextState = OWN;
                    end else begin
                        w_nextPtr = wrapInc(w_grantIdx);
                    end
                end
            end
            OWN: begin
                // A full FIFO stalls the owner indefinitely; only a dropped valid gives up the burst.
                if (req_valid[r_owner]) begin
                    if (!w_full) begin
                        w_ready[r_owner] = 1'b1;
                        if (int'(r_beats) + 1 >= MAX_BURST) begin
                            w_nextState = IDLE;
                            w_nextPtr   = wrapInc(r_owner);
                            w_nextBeats = '0;
                        end else begin
                            w_nextBeats = r_beats + 1'b1;
                        end
                    end
                end else begin
                    w_nextState = IDLE;
                    w_nextPtr   = wrapInc(r_owner);
                    w_nextBeats = '0;
                end
            end
            default: w_nextState = IDLE;
        endcase
        if (rst) begin
            w_ready = '0;
        end
    end

    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_ready[i] && req_valid[i]) begin
                w_wdata = w_wdata | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_winc = |(w_ready & req_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_rrPtr        <= '0;
            r_owner        <= '0;
            r_beats        <= '0;
            r_level        <= '0;
            r_errUnderflow <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_rrPtr <= w_nextPtr;
            r_owner <= w_nextOwner;
            r_beats <= w_nextBeats;
            if (w_winc && !w_rdEff) begin
                r_level <= r_level + 1'b1;
            end else if (w_rdEff && !w_winc) begin
                r_level <= r_level - 1'b1;
            end
            if (rinc_mon && w_empty) begin
                r_errUnderflow <= 1'b1;
            end
        end
    end

    assign req_ready     = w_ready;
    assign winc          = w_winc;
    assign wdata         = w_wdata;
    assign full          = w_full;
    assign empty         = w_empty;
    assign level         = r_level;
    assign err_underflow = r_errUnderflow;

endmodule
